// File: rtl/latch_drive_ctrl.sv
// latch_drive_ctrl: synchronizes and debounces raw set/clear requests and turns
// each accepted request into a fixed-width active-low pulse on S_N (clear) or
// R_N (set) of a downstream cross-coupled SR latch. It never drives both low.
// Latency: raw input first sampled at edge k -> drive low after edge k+2+DEBOUNCE_CYCLES.
// Backpressure: requests arriving while busy are held as pending flags; a set
// and a clear accepted in the same cycle keep the clear and strobe DROP.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   SET_REQ, CLR_REQ  raw asynchronous requests, active-high
//   S_N, R_N          latch drives, idle high; S_N low clears Q, R_N low sets Q
//   BUSY              high while a pulse or the following gap is in progress
//   Q_EXP             expected latch Q after the last completed pulse
//   DROP              one-cycle strobe when a set request was discarded
module latch_drive_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 3,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned INIT_CLEAR      = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_REQ,
    input  logic CLR_REQ,
    output logic S_N,
    output logic R_N,
    output logic BUSY,
    output logic Q_EXP,
    output logic DROP
);

    // Bit 0 of the per-input vectors is the set request, bit 1 the clear request.
    localparam int IDX_SET = 0;
    localparam int IDX_CLR = 1;

    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_MAX   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW       = $clog2(PH_MAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Synchronizer and debounce state
    logic [1:0]    s1_q, s1_d;
    logic [1:0]    s2_q, s2_d;
    logic [1:0]    deb_q, deb_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];
    logic [1:0]    rise;

    // Request bookkeeping and pulse sequencer
    logic          set_pend_q, set_pend_d;
    logic          clr_pend_q, clr_pend_d;
    logic          init_done_q, init_done_d;
    state_t        state_q, state_d;
    logic [CW-1:0] ph_q, ph_d;
    logic          s_n_q, s_n_d;
    logic          r_n_q, r_n_d;
    logic          busy_q, busy_d;
    logic          q_exp_q, q_exp_d;
    logic          drop_q, drop_d;
    logic          start;

    // Synchronize, then debounce: a change is accepted only after
    // DEBOUNCE_CYCLES consecutive disagreeing samples of the second sync stage.
    always_comb begin
        s1_d = {CLR_REQ, SET_REQ};
        s2_d = s1_q;
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            rise[i]  = 1'b0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    rise[i]  = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        s_n_d       = s_n_q;
        r_n_d       = r_n_q;
        q_exp_d     = q_exp_q;
        set_pend_d  = set_pend_q;
        clr_pend_d  = clr_pend_q;
        drop_d      = 1'b0;
        init_done_d = 1'b1;
        start       = 1'b0;

        case (state_q)
            IDLE: begin
                start = set_pend_q | clr_pend_q;
            end
            PULSE: begin
                if (ph_q == P_LAST) begin
                    state_d = GAP;
                    ph_d    = '0;
                    // A low R_N pulse is a set; a low S_N pulse is a clear.
                    q_exp_d = ~r_n_q;
                    s_n_d   = 1'b1;
                    r_n_d   = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            GAP: begin
                if (ph_q == G_LAST) begin
                    ph_d    = '0;
                    state_d = IDLE;
                    // Chain straight into the next pulse so the gap is exactly
                    // GAP_CYCLES long when work is already queued.
                    start   = set_pend_q | clr_pend_q;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
                s_n_d   = 1'b1;
                r_n_d   = 1'b1;
            end
        endcase

        // Clear wins over set when both are pending.
        if (start) begin
            state_d = PULSE;
            ph_d    = '0;
            if (clr_pend_q) begin
                s_n_d      = 1'b0;
                clr_pend_d = 1'b0;
            end else begin
                r_n_d      = 1'b0;
                set_pend_d = 1'b0;
            end
        end

        // New events are applied after the start so a request arriving on the
        // same edge a pulse begins is not lost.
        if (rise[IDX_SET] && rise[IDX_CLR]) begin
            clr_pend_d = 1'b1;
            set_pend_d = 1'b0;
            drop_d     = 1'b1;
        end else if (rise[IDX_CLR]) begin
            clr_pend_d = 1'b1;
        end else if (rise[IDX_SET]) begin
            set_pend_d = 1'b1;
        end

        if ((INIT_CLEAR != 0) && !init_done_q) begin
            clr_pend_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // Drives reset to high asynchronously, so a reset mid-pulse releases the
    // latch input immediately without any low glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q        <= '0;
            s2_q        <= '0;
            deb_q       <= '0;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            set_pend_q  <= 1'b0;
            clr_pend_q  <= 1'b0;
            init_done_q <= 1'b0;
            state_q     <= IDLE;
            ph_q        <= '0;
            s_n_q       <= 1'b1;
            r_n_q       <= 1'b1;
            busy_q      <= 1'b0;
            q_exp_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            deb_q       <= deb_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            set_pend_q  <= set_pend_d;
            clr_pend_q  <= clr_pend_d;
            init_done_q <= init_done_d;
            state_q     <= state_d;
            ph_q        <= ph_d;
            s_n_q       <= s_n_d;
            r_n_q       <= r_n_d;
            busy_q      <= busy_d;
            q_exp_q     <= q_exp_d;
            drop_q      <= drop_d;
        end
    end

    assign S_N   = s_n_q;
    assign R_N   = r_n_q;
    assign BUSY  = busy_q;
    assign Q_EXP = q_exp_q;
    assign DROP  = drop_q;

endmodule

// File: tb/tb_latch_drive_ctrl.sv
// Directed bench for latch_drive_ctrl with default parameters.
// Each capture index j is the sample taken 1 time unit after the j-th rising
// edge of the capture; raw inputs are applied right after each sample.
module tb_latch_drive_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic SET_REQ;
    logic CLR_REQ;
    logic S_N, R_N, BUSY, Q_EXP, DROP;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] sn_h, rn_h, busy_h, drop_h, q_h;

    latch_drive_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .SET_REQ (SET_REQ),
        .CLR_REQ (CLR_REQ),
        .S_N     (S_N),
        .R_N     (R_N),
        .BUSY    (BUSY),
        .Q_EXP   (Q_EXP),
        .DROP    (DROP)
    );

    always #5 CLK = ~CLK;

    // The two drives must never be low together in any cycle.
    always @(negedge CLK) begin
        vectors++;
        if (S_N === 1'b0 && R_N === 1'b0) begin
            miscompares++;
            $display("FAIL overlap at %0t: S_N=%b R_N=%b required not both 0", $time, S_N, R_N);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        SET_REQ = 1'b0;
        CLR_REQ = 1'b0;
        repeat (n) tick();
    endtask

    // Raw input for capture index j is high when on <= j < off.
    task automatic capture(input int n, input int s_on, input int s_off,
                           input int c_on, input int c_off);
        sn_h = '1; rn_h = '1; busy_h = '0; drop_h = '0; q_h = '0;
        SET_REQ = (0 >= s_on) && (0 < s_off);
        CLR_REQ = (0 >= c_on) && (0 < c_off);
        for (int j = 0; j < n; j++) begin
            tick();
            sn_h[j]   = S_N;
            rn_h[j]   = R_N;
            busy_h[j] = BUSY;
            drop_h[j] = DROP;
            q_h[j]    = Q_EXP;
            SET_REQ = (j + 1 >= s_on) && (j + 1 < s_off);
            CLR_REQ = (j + 1 >= c_on) && (j + 1 < c_off);
        end
    endtask

    function automatic int first_low(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) if (v[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int count_low(input logic [63:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (v[i] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_high(input logic [63:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (v[i] == 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        int v;
        RST = 1'b1; SET_REQ = 1'b0; CLR_REQ = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({S_N, R_N, BUSY, Q_EXP, DROP} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b required 11000", {S_N, R_N, BUSY, Q_EXP, DROP});
        end
        RST = 1'b0;
        capture(10, 0, 0, 0, 0);
        v = first_low(sn_h, 10); vectors++;
        if (v !== 1) begin miscompares++; $display("FAIL init_sn_start got %0d required 1", v); end
        v = count_low(sn_h, 10); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL init_sn_width got %0d required 3", v); end
        v = count_low(rn_h, 10); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL init_rn_low got %0d required 0", v); end
        v = count_high(busy_h, 10); vectors++;
        if (v !== 5) begin miscompares++; $display("FAIL init_busy_len got %0d required 5", v); end
        vectors++;
        if (Q_EXP !== 1'b0) begin miscompares++; $display("FAIL init_q_exp got %b required 0", Q_EXP); end
    endtask

    task automatic test_set_hold();
        int v;
        capture(14, 0, 100, 0, 0);
        v = first_low(rn_h, 14); vectors++;
        if (v !== 6) begin miscompares++; $display("FAIL set_rn_start got %0d required 6", v); end
        v = count_low(rn_h, 14); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL set_rn_width got %0d required 3", v); end
        v = count_low(sn_h, 14); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL set_sn_low got %0d required 0", v); end
        v = count_high(busy_h, 14); vectors++;
        if (v !== 5) begin miscompares++; $display("FAIL set_busy_len got %0d required 5", v); end
        vectors++;
        if (q_h[8] !== 1'b0 || q_h[9] !== 1'b1) begin
            miscompares++; $display("FAIL set_q_update got q8=%b q9=%b required 0 1", q_h[8], q_h[9]);
        end
        vectors++;
        if (BUSY !== 1'b0 || Q_EXP !== 1'b1) begin
            miscompares++; $display("FAIL set_final got BUSY=%b Q_EXP=%b required 0 1", BUSY, Q_EXP);
        end
        idle(12);
    endtask

    task automatic test_glitch();
        int v;
        capture(16, 0, 3, 0, 0);
        v = count_low(rn_h, 16) + count_low(sn_h, 16); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL glitch_drive_low got %0d required 0", v); end
        v = count_high(busy_h, 16) + count_high(drop_h, 16); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL glitch_busy_drop got %0d required 0", v); end
        vectors++;
        if (Q_EXP !== 1'b1) begin miscompares++; $display("FAIL glitch_q_exp got %b required 1", Q_EXP); end
        idle(4);
    endtask

    task automatic test_reset_mid_pulse();
        int v;
        capture(8, 0, 100, 0, 0);
        vectors++;
        if (rn_h[7] !== 1'b0 || rn_h[6] !== 1'b0) begin
            miscompares++; $display("FAIL midrst_pre_rn got %b%b required 00", rn_h[6], rn_h[7]);
        end
        #2;
        RST = 1'b1;
        SET_REQ = 1'b0;
        #1;
        vectors++;
        if ({S_N, R_N, BUSY, Q_EXP} !== 4'b1100) begin
            miscompares++; $display("FAIL midrst_async got %b required 1100", {S_N, R_N, BUSY, Q_EXP});
        end
        tick(); tick();
        RST = 1'b0;
        capture(10, 0, 0, 0, 0);
        v = first_low(sn_h, 10); vectors++;
        if (v !== 1) begin miscompares++; $display("FAIL midrst_init_start got %0d required 1", v); end
        v = count_low(sn_h, 10); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL midrst_init_width got %0d required 3", v); end
        v = count_low(rn_h, 10); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL midrst_rn_low got %0d required 0", v); end
        idle(4);
    endtask

    task automatic test_debounce_boundary();
        int v;
        capture(14, 0, 4, 0, 0);
        v = first_low(rn_h, 14); vectors++;
        if (v !== 6) begin miscompares++; $display("FAIL boundary_rn_start got %0d required 6", v); end
        v = count_low(rn_h, 14); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL boundary_rn_width got %0d required 3", v); end
        vectors++;
        if (Q_EXP !== 1'b1) begin miscompares++; $display("FAIL boundary_q_exp got %b required 1", Q_EXP); end
        idle(10);
    endtask

    task automatic test_simultaneous();
        int v;
        capture(16, 0, 10, 0, 10);
        v = first_low(sn_h, 16); vectors++;
        if (v !== 6) begin miscompares++; $display("FAIL simul_sn_start got %0d required 6", v); end
        v = count_low(sn_h, 16); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL simul_sn_width got %0d required 3", v); end
        v = count_low(rn_h, 16); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL simul_rn_low got %0d required 0", v); end
        v = count_high(drop_h, 16); vectors++;
        if (v !== 1 || drop_h[5] !== 1'b1) begin
            miscompares++; $display("FAIL simul_drop got count %0d at5 %b required 1 1", v, drop_h[5]);
        end
        vectors++;
        if (Q_EXP !== 1'b0) begin miscompares++; $display("FAIL simul_q_exp got %b required 0", Q_EXP); end
        idle(10);
    endtask

    task automatic test_back_to_back();
        int v;
        capture(20, 0, 12, 2, 14);
        v = first_low(rn_h, 20); vectors++;
        if (v !== 6) begin miscompares++; $display("FAIL b2b_rn_start got %0d required 6", v); end
        v = count_low(rn_h, 20); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL b2b_rn_width got %0d required 3", v); end
        v = first_low(sn_h, 20); vectors++;
        if (v !== 11) begin miscompares++; $display("FAIL b2b_sn_start got %0d required 11", v); end
        v = count_low(sn_h, 20); vectors++;
        if (v !== 3) begin miscompares++; $display("FAIL b2b_sn_width got %0d required 3", v); end
        vectors++;
        if (q_h[10] !== 1'b1) begin miscompares++; $display("FAIL b2b_q_mid got %b required 1", q_h[10]); end
        v = count_high(busy_h, 20); vectors++;
        if (v !== 10) begin miscompares++; $display("FAIL b2b_busy_len got %0d required 10", v); end
        v = count_high(drop_h, 20); vectors++;
        if (v !== 0) begin miscompares++; $display("FAIL b2b_drop got %0d required 0", v); end
        vectors++;
        if (Q_EXP !== 1'b0 || BUSY !== 1'b0) begin
            miscompares++; $display("FAIL b2b_final got Q_EXP=%b BUSY=%b required 0 0", Q_EXP, BUSY);
        end
        idle(10);
    endtask

    initial begin
        RST = 1'b1;
        SET_REQ = 1'b0;
        CLR_REQ = 1'b0;
        test_reset();
        idle(4);
        test_set_hold();
        test_glitch();
        test_reset_mid_pulse();
        test_debounce_boundary();
        test_simultaneous();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
